// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: two-direction intersection controller with
// minimum-green hold, yellow and all-red clearance, pedestrian walk
// requests and emergency preemption.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - asynchronous active-low reset
//   ped_ns_req   - NS pedestrian button (sampled every cycle)
//   ped_ew_req   - EW pedestrian button (sampled every cycle)
//   car_ew       - EW vehicle presence (level)
//   preempt      - emergency preemption request (level)
//   nslight      - NS lamps {red,yellow,green}, one-hot, registered
//   ewlight      - EW lamps {red,yellow,green}, one-hot, registered
//   walk_ns      - NS pedestrian walk, registered
//   walk_ew      - EW pedestrian walk, registered
//   phase        - current state code, registered
//   req_pending  - latched pedestrian requests {ew,ns}, registered
//
// state | meaning
// NS_G  | NS green, EW red; holds past minimum green until EW demand
// NS_Y  | NS yellow, EW red
// AR1   | all-red clearance before EW green
// EW_G  | EW green, NS red; fixed duration
// EW_Y  | EW yellow, NS red
// AR2   | all-red clearance before NS green; reset state
// PRE   | emergency preemption, all-red while preempt is held
module traffic_phase_scheduler #(
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_ns_req,
    input  logic       ped_ew_req,
    input  logic       car_ew,
    input  logic       preempt,
    output logic [2:0] nslight,
    output logic [2:0] ewlight,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase,
    output logic [1:0] req_pending
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        PRE  = 3'd6
    } state_t;

    localparam logic [7:0] T_GREEN  = 8'(GREEN_CYC - 1);
    localparam logic [7:0] T_YELLOW = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] T_ALLRED = 8'(ALLRED_CYC - 1);
    // Walk stays on while the next cycle's timer is at or above this value,
    // i.e. for the first WALK_CYC cycles of the green.
    localparam logic [7:0] T_WALK_MIN = 8'(GREEN_CYC - WALK_CYC);

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt, timer_dec;
    logic       tmo, entering;
    logic [1:0] req_nxt;
    logic       walk_ns_nxt, walk_ew_nxt;

    function automatic logic [7:0] load_val(state_t s);
        case (s)
            NS_G, EW_G: load_val = T_GREEN;
            NS_Y, EW_Y: load_val = T_YELLOW;
            AR1, AR2:   load_val = T_ALLRED;
            default:    load_val = 8'd0;
        endcase
    endfunction

    function automatic logic [5:0] lamps(state_t s);
        case (s)
            NS_G:    lamps = 6'b001_100;
            NS_Y:    lamps = 6'b010_100;
            EW_G:    lamps = 6'b100_001;
            EW_Y:    lamps = 6'b100_010;
            default: lamps = 6'b100_100;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        tmo       = (timer == 8'd0);
        timer_dec = tmo ? 8'd0 : timer - 8'd1;
        case (state)
            NS_G: if (preempt || (tmo && (car_ew || req_pending[1]))) state_nxt = NS_Y;
            NS_Y: if (tmo) state_nxt = preempt ? PRE : AR1;
            AR1:  if (preempt) state_nxt = PRE;
                  else if (tmo) state_nxt = EW_G;
            EW_G: if (preempt || tmo) state_nxt = EW_Y;
            EW_Y: if (tmo) state_nxt = preempt ? PRE : AR2;
            AR2:  if (preempt) state_nxt = PRE;
                  else if (tmo) state_nxt = NS_G;
            PRE:  if (!preempt) state_nxt = AR2;
            default: state_nxt = AR2;
        endcase
        entering  = (state_nxt != state);
        timer_nxt = entering ? load_val(state_nxt) : timer_dec;

        // Clear on green entry beats a same-edge set: that green serves it.
        req_nxt = req_pending | {ped_ew_req, ped_ns_req};
        if (entering && state_nxt == NS_G) req_nxt[0] = 1'b0;
        if (entering && state_nxt == EW_G) req_nxt[1] = 1'b0;

        walk_ns_nxt = 1'b0;
        if (state_nxt == NS_G)
            walk_ns_nxt = entering ? (req_pending[0] | ped_ns_req)
                                   : (walk_ns && !tmo && timer_dec >= T_WALK_MIN);
        walk_ew_nxt = 1'b0;
        if (state_nxt == EW_G)
            walk_ew_nxt = entering ? (req_pending[1] | ped_ew_req)
                                   : (walk_ew && !tmo && timer_dec >= T_WALK_MIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= AR2;
            timer       <= T_ALLRED;
            nslight     <= 3'b100;
            ewlight     <= 3'b100;
            walk_ns     <= 1'b0;
            walk_ew     <= 1'b0;
            phase       <= AR2;
            req_pending <= 2'b00;
        end else begin
            state                <= state_nxt;
            timer                <= timer_nxt;
            {nslight, ewlight}   <= lamps(state_nxt);
            walk_ns              <= walk_ns_nxt;
            walk_ew              <= walk_ew_nxt;
            phase                <= state_nxt;
            req_pending          <= req_nxt;
        end
    end

endmodule
